// File: rtl/branch_predictor_btb_if.sv
// branch_predictor_btb_if: fetch lookup, pipeline control and EX training signals of the branch predictor
interface branch_predictor_btb_if;
  logic [31:0] PC_IF, PredictPC, PC_EX_br, br_target_EX, br_count, mispred_count;
  logic PredictF, StallD, FlushD, StallE, FlushE, PredictE, is_br_EX, br_taken_EX;
  modport master (
    output PC_IF, StallD, FlushD, StallE, FlushE, is_br_EX, br_taken_EX, PC_EX_br, br_target_EX,
    input PredictF, PredictPC, PredictE, br_count, mispred_count
  );
  modport slave (
    input PC_IF, StallD, FlushD, StallE, FlushE, is_br_EX, br_taken_EX, PC_EX_br, br_target_EX,
    output PredictF, PredictPC, PredictE, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit counters, prediction carried to EX, trained in EX
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W = 4
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_btb_if.slave bp
);
  localparam int TAG_W = 30 - IDX_W;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [31:0] target [ENTRIES];
  logic [1:0] ctr [ENTRIES];
  logic [IDX_W-1:0] idx_f, idx_e;
  logic hit_f, hit_e, upd, pred_d, pred_e;
  assign idx_f = bp.PC_IF[IDX_W+1:2];
  assign idx_e = bp.PC_EX_br[IDX_W+1:2];
  assign hit_f = valid[idx_f] && tag[idx_f] == bp.PC_IF[31:IDX_W+2];
  assign hit_e = valid[idx_e] && tag[idx_e] == bp.PC_EX_br[31:IDX_W+2];
  assign upd = bp.is_br_EX && !bp.StallE;
  assign bp.PredictF = hit_f && ctr[idx_f][1];
  assign bp.PredictPC = hit_f ? target[idx_f] : 32'h0;
  assign bp.PredictE = pred_e;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd && (hit_e || bp.br_taken_EX)) begin
      valid[idx_e] <= 1'b1;
      ctr[idx_e] <= !hit_e ? 2'b10 :
                    bp.br_taken_EX ? (ctr[idx_e] == 2'b11 ? 2'b11 : ctr[idx_e] + 2'd1) :
                    (ctr[idx_e] == 2'b00 ? 2'b00 : ctr[idx_e] - 2'd1);
    end
  // Tag and target need no reset: valid gates every use of them.
  always_ff @(posedge clk)
    if (rst_n && upd && bp.br_taken_EX) begin
      tag[idx_e] <= bp.PC_EX_br[31:IDX_W+2];
      target[idx_e] <= bp.br_target_EX;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pred_d <= 1'b0;
      pred_e <= 1'b0;
      bp.br_count <= '0;
      bp.mispred_count <= '0;
    end else begin
      pred_d <= bp.FlushD ? 1'b0 : bp.StallD ? pred_d : bp.PredictF;
      pred_e <= bp.FlushE ? 1'b0 : bp.StallE ? pred_e : pred_d;
      if (upd && bp.br_count != '1) bp.br_count <= bp.br_count + 32'd1;
      if (upd && bp.br_taken_EX != pred_e && bp.mispred_count != '1)
        bp.mispred_count <= bp.mispred_count + 32'd1;
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed plan plus random traffic checked against a table-level model every cycle
module tb_branch_predictor_btb;
  localparam int ENTRIES = 16;
  localparam int IDX_W = 4;
  logic clk = 1'b0, rst_n = 1'b1, go = 1'b0;
  int compared = 0, mismatched = 0;
  branch_predictor_btb_if bif();
  branch_predictor_btb #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (.clk(clk), .rst_n(rst_n), .bp(bif));
  always #5 clk = ~clk;

  bit m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int m_ctr [ENTRIES];
  bit m_d, m_e;
  longint m_br, m_mis;

  function automatic int slot(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction
  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[slot(pc)] && m_owner[slot(pc)] == (pc & ~32'h3);
  endfunction
  function automatic bit m_pf(logic [31:0] pc);
    return m_hit(pc) && m_ctr[slot(pc)] >= 2;
  endfunction
  function automatic logic [31:0] m_ppc(logic [31:0] pc);
    return m_hit(pc) ? m_tgt[slot(pc)] : 32'h0;
  endfunction
  function automatic logic [31:0] sat(longint v);
    return v > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i] = 1;
    end
    m_d = 0; m_e = 0; m_br = 0; m_mis = 0;
  endtask

  task automatic m_step();
    bit pf, upd;
    int s;
    if (!rst_n) return;
    pf = m_pf(bif.PC_IF);
    upd = bif.is_br_EX && !bif.StallE;
    s = slot(bif.PC_EX_br);
    if (upd) begin
      m_br++;
      if (bif.br_taken_EX != m_e) m_mis++;
      if (m_hit(bif.PC_EX_br)) begin
        m_ctr[s] = bif.br_taken_EX ? (m_ctr[s] < 3 ? m_ctr[s] + 1 : 3) : (m_ctr[s] > 0 ? m_ctr[s] - 1 : 0);
        if (bif.br_taken_EX) m_tgt[s] = bif.br_target_EX;
      end else if (bif.br_taken_EX) begin
        m_valid[s] = 1;
        m_owner[s] = bif.PC_EX_br & ~32'h3;
        m_tgt[s] = bif.br_target_EX;
        m_ctr[s] = 2;
      end
    end
    m_e = bif.FlushE ? 0 : bif.StallE ? m_e : m_d;
    m_d = bif.FlushD ? 0 : bif.StallD ? m_d : pf;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (go) begin
    chk("PredictF", {31'b0, bif.PredictF}, {31'b0, m_pf(bif.PC_IF)});
    chk("PredictPC", bif.PredictPC, m_ppc(bif.PC_IF));
    chk("PredictE", {31'b0, bif.PredictE}, {31'b0, m_e});
    chk("br_count", bif.br_count, sat(m_br));
    chk("mispred_count", bif.mispred_count, sat(m_mis));
  end

  task automatic step();
    @(posedge clk);
    m_step();
    #2;
  endtask

  task automatic train(logic [31:0] pc, bit tk, logic [31:0] tgt);
    bif.is_br_EX = 1; bif.br_taken_EX = tk; bif.PC_EX_br = pc; bif.br_target_EX = tgt;
    step();
    bif.is_br_EX = 0;
  endtask

  initial begin
    longint br0;
    bif.PC_IF = 0; bif.StallD = 0; bif.FlushD = 0; bif.StallE = 0; bif.FlushE = 0;
    bif.is_br_EX = 0; bif.br_taken_EX = 0; bif.PC_EX_br = 0; bif.br_target_EX = 0;
    #1 rst_n = 0;
    m_reset();
    go = 1;
    step(); step();
    chk("reset PredictE", {31'b0, bif.PredictE}, 32'h0);
    chk("reset br_count", bif.br_count, 32'h0);
    rst_n = 1;
    // Plan 1: cold miss, then allocate
    bif.PC_IF = 32'h100;
    #1 chk("cold PredictF", {31'b0, bif.PredictF}, 32'h0);
    chk("cold PredictPC", bif.PredictPC, 32'h0);
    train(32'h100, 1, 32'h200);
    #1 chk("alloc PredictF", {31'b0, bif.PredictF}, 32'h1);
    chk("alloc PredictPC", bif.PredictPC, 32'h200);
    chk("alloc br_count", bif.br_count, 32'h1);
    chk("alloc mispred", bif.mispred_count, 32'h1);
    // Plan 2: hysteresis
    train(32'h100, 0, 32'h0);
    #1 chk("ctr01 PredictF", {31'b0, bif.PredictF}, 32'h0);
    train(32'h100, 1, 32'h200);
    train(32'h100, 1, 32'h200);
    train(32'h100, 0, 32'h0);
    #1 chk("ctr10 PredictF", {31'b0, bif.PredictF}, 32'h1);
    // Plan 3: aliasing replaces the entry
    train(32'h140, 1, 32'h300);
    #1 chk("alias old PredictF", {31'b0, bif.PredictF}, 32'h0);
    bif.PC_IF = 32'h140;
    #1 chk("alias new PredictF", {31'b0, bif.PredictF}, 32'h1);
    chk("alias new PredictPC", bif.PredictPC, 32'h300);
    // Plan 4: pipeline, flush, stall
    step(); step();
    chk("pipe PredictE", {31'b0, bif.PredictE}, 32'h1);
    bif.FlushE = 1;
    step();
    chk("flushE PredictE", {31'b0, bif.PredictE}, 32'h0);
    bif.FlushE = 0;
    step();
    bif.PC_IF = 32'h0; bif.StallD = 1; bif.StallE = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall PredictE", {31'b0, bif.PredictE}, 32'h1);
    end
    bif.StallD = 0;
    // Plan 5: training gated by StallE, same-cycle lookup sees old entry
    br0 = m_br;
    bif.is_br_EX = 1; bif.br_taken_EX = 1; bif.PC_EX_br = 32'h180; bif.br_target_EX = 32'h400;
    step(); step();
    chk("gated br_count", bif.br_count, sat(br0));
    bif.StallE = 0; bif.PC_IF = 32'h180;
    #1 chk("same-cycle PredictF", {31'b0, bif.PredictF}, 32'h0);
    step();
    bif.is_br_EX = 0;
    #1 chk("post-update PredictPC", bif.PredictPC, 32'h400);
    chk("one update br_count", bif.br_count, sat(br0 + 1));
    // Plan 6: asynchronous reset between edges
    #1 rst_n = 0;
    m_reset();
    #1 chk("async PredictF", {31'b0, bif.PredictF}, 32'h0);
    chk("async PredictPC", bif.PredictPC, 32'h0);
    chk("async mispred", bif.mispred_count, 32'h0);
    step();
    rst_n = 1;
    #1 chk("post-reset miss", {31'b0, bif.PredictF}, 32'h0);
    // Random traffic with aliasing tags, stalls, flushes and rare resets
    for (int n = 0; n < 3000; n++) begin
      bif.PC_IF = ($urandom_range(0, 1) << 31) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      bif.PC_EX_br = ($urandom_range(0, 1) << 31) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      bif.br_target_EX = $urandom;
      bif.is_br_EX = $urandom_range(0, 2) != 0;
      bif.br_taken_EX = $urandom_range(0, 1);
      bif.StallD = $urandom_range(0, 7) == 0;
      bif.StallE = $urandom_range(0, 7) == 0;
      bif.FlushD = $urandom_range(0, 9) == 0;
      bif.FlushE = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 0;
        m_reset();
        step();
        rst_n = 1;
      end else step();
    end
    go = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Producer side of the fetch-prediction interface consumed by the next-PC generator.
- Looks up the IF-stage PC in a direct-mapped BTB with 2-bit saturating counters (BHT) and drives PredictF/PredictPC combinationally.
- Carries each prediction down to EX as PredictE through internal ID/EX registers.
- Trains on branch resolution in EX and keeps branch and mispredict statistics.

Parameters:
- ENTRIES, 16: number of BTB/BHT entries; power of two, 4..256.
- IDX_W, 4: log2(ENTRIES); index = PC[IDX_W+1:2].

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PC_IF  input  32  PC currently being fetched.
- PredictF  output  1  predict-taken for PC_IF.
- PredictPC  output  32  predicted target for PC_IF.
- StallD  input  1  hold the ID prediction register.
- FlushD  input  1  clear the ID prediction register.
- StallE  input  1  hold the EX prediction register; also blocks training.
- FlushE  input  1  clear the EX prediction register.
- PredictE  output  1  prediction that travelled with the instruction now in EX.
- is_br_EX  input  1  EX holds a conditional branch.
- br_taken_EX  input  1  resolved outcome of that branch.
- PC_EX_br  input  32  address of the EX branch (not PC+4).
- br_target_EX  input  32  resolved taken target.
- br_count  output  32  resolved branches trained.
- mispred_count  output  32  resolved branches where br_taken_EX != PredictE.

Behaviour:

Entry layout and lookup:
- Each entry holds valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0].
- Lookup is combinational with no added latency.
  - hit = valid[idx] && tag match on PC_IF.
  - PredictF = hit && ctr[1].
  - PredictPC = hit ? target : 32'h0.

Prediction pipeline:
- pred_D, rising edge: FlushD -> 0; else StallD -> hold; else PredictF.
- pred_E, rising edge: FlushE -> 0; else StallE -> hold; else pred_D.
- Flush has priority over stall in both registers.
- PredictE = pred_E.

Training:
- Training fires on a rising edge when is_br_EX && !StallE ("update").
- Hit on PC_EX_br:
  - taken: ctr increments, saturating at 2'b11; target <= br_target_EX.
  - not taken: ctr decrements, saturating at 2'b00; target is unchanged.
- Miss and taken: allocate the entry, overwriting whatever is there. Set valid=1, tag, target=br_target_EX, ctr=2'b10.
- Miss and not taken: no change.

Statistics:
- On update, br_count increments by 1.
- On update with br_taken_EX != PredictE, mispred_count also increments by 1.
- Both counters saturate at 32'hFFFF_FFFF; they do not wrap.

Simultaneous events:
- Lookup and update on the same index in the same cycle: the lookup returns the pre-update entry. The new value is visible from the next cycle.
- Flush/stall signals and training are independent. An update uses the PredictE value present before the edge.

Reset:
- rst_n low asynchronously clears all valid bits, sets all ctr to 2'b01, and clears pred_D, pred_E, br_count and mispred_count.
- Output values during and immediately after reset: PredictF=0, PredictPC=0, PredictE=0, both counters 0.
- Reset asserted mid-operation discards any pending update in that cycle.

Other rules:
- Only conditional branches are trained.
- jal/jalr never touch this block.
- All arithmetic is unsigned; PC bits [1:0] are ignored.

Test Plan:
1. Reset, then PC_IF=0x100 -> PredictF=0, PredictPC=0. Update PC_EX_br=0x100, taken, target 0x200 -> next cycle PC_IF=0x100 gives PredictF=1, PredictPC=0x200; br_count=1, mispred_count=1.
2. Hysteresis: from ctr=2'b10, train 0x100 not-taken once -> PredictF=0 (ctr 01). Train taken twice -> ctr 11; one not-taken -> PredictF still 1.
3. Aliasing with ENTRIES=16: allocate 0x100 taken, then 0x140 (same index, different tag) taken, target 0x300 -> PC_IF=0x100 misses (PredictF=0), PC_IF=0x140 predicts 0x300.
4. Pipeline: PredictF=1 at cycle n with no stalls -> PredictE=1 at n+2. Assert FlushE at n+1 edge -> PredictE=0. StallD+StallE held for 3 cycles -> PredictE unchanged.
5. Training gating: is_br_EX=1 with StallE=1 for 2 cycles then StallE=0 -> exactly one update; br_count +1. Same-index lookup in the update cycle shows the old entry.
6. Async reset: drop rst_n mid-cycle between edges with entries valid -> outputs 0 immediately; after release, a previously trained PC misses and both counters read 0.
